revaluate_ctrl: RTL and testbench
=================================

# revaluate_ctrl

Sequencing controller for the revaluate datapath (the chi-style per-cell pass `cell ^ (~next & next_next)` over the 5×5×64 state). It accepts a start request from the round controller and drives the datapath `count`/`write` strobes, one cell per clock. It cross-checks the datapath's `done` against its own shadow cell counter and keeps the datapath counters aligned after an abort or error. It reports completion through a valid/ack handshake.

## Interface
- `NUM_ITER`, 1600: cells per pass (`NUM_ROW*NUM_COLUMN*NUM_PAGE`).
- `CNT_W`, 11: shadow counter width; must satisfy 2^CNT_W ≥ NUM_ITER.

- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset. Clears the FSM and counters.
- `start` in 1: pass request; accepted only when `ready`=1.
- `abort` in 1: cancel the pass in progress; honoured in EXEC only.
- `dp_done` in 1: datapath `done`, i.e. page-counter overflow. Combinational in the cycle of the last `count`.
- `out_ack` in 1: consumer accepts the result.
- `dp_count` out 1: datapath `count`.
- `dp_write` out 1: datapath `write`.
- `ready` out 1: idle, can accept `start`.
- `busy` out 1: pass or drain in progress; upstream holds `data_in` stable while high.
- `out_valid` out 1: datapath `data_out` is complete and stable.
- `err` out 1: sync error on the last pass; valid while `out_valid`=1.
- `progress` out CNT_W: shadow count of cells processed in the current pass.

## Operation
- FSM states: IDLE, EXEC, DRAIN, DONE. All outputs are Moore, decoded from state and registers.
- Reset values: state=IDLE, `ready`=1, all other outputs 0, `progress`=0, error latch=0.
- IDLE
  - `ready`=1.
  - `start`=1 → EXEC, `progress`←0, error latch←0.
- EXEC
  - `dp_write`=1 and `dp_count`=1 every cycle. The memory write and counter advance land on the same edge, so one cell is processed per cycle.
  - `progress` increments each cycle.
  - Last cycle (`progress`=NUM_ITER−1) with `dp_done`=1 → DONE, err=0.
  - Last cycle with `dp_done`=0 → DRAIN, error latch←1. The datapath counters are behind.
  - `dp_done`=1 before the last cycle → DONE, error latch←1. The datapath counters have wrapped to 0, so no drain is needed.
  - `abort`=1 (priority over the rules above) → DRAIN with error latch unchanged. The cell in that cycle is still written and counted.
- DRAIN
  - `dp_count`=1, `dp_write`=0. Advances the datapath counters to wrap-around without touching memory.
  - `dp_done`=1 → IDLE after abort, or → DONE after an error.
  - Watchdog: if `dp_done` does not appear within NUM_ITER drain cycles → DONE, err=1.
- DONE
  - `out_valid`=1, `err` = error latch.
  - `out_ack`=1 → IDLE.
- `start` is ignored outside IDLE. `abort` is ignored outside EXEC. `busy` = EXEC or DRAIN.
- `progress` saturates at NUM_ITER and is reused as the watchdog counter in DRAIN (cleared on DRAIN entry).

## Timing
- `start` sampled at edge T (IDLE) → EXEC from T+1. First `dp_write` is in cycle T+1.
- EXEC lasts exactly NUM_ITER cycles → `out_valid` rises at T+1+NUM_ITER. Start-to-valid latency is NUM_ITER+1 cycles.
- `out_valid` is held until the edge where `out_ack`=1. `ready` rises the next cycle; no back-to-back start in the ack cycle.
- `out_ack` asserted before `out_valid` has no effect.
- `abort` and the last-cycle check in the same cycle: abort wins → DRAIN. The datapath is already at wrap, so `dp_done`=1 in the first DRAIN cycle causes one extra count and misalignment. To avoid this, `abort` in the last EXEC cycle is ignored and the pass completes normally.
- Async `rst` mid-pass: outputs go to reset values immediately. The datapath shares `rst`, so both restart aligned.

## Test plan
- Normal pass:
  - Stimulus: `rst` pulse, `start` one cycle, model `dp_done` at the 1600th count.
  - Response: exactly 1600 cycles of `dp_write`=`dp_count`=1; `out_valid`=1 at start+1601 with err=0; `out_ack` → `ready`=1 next cycle.
- Abort mid-pass:
  - Stimulus: `abort` at progress=500.
  - Response: 501 writes total; DRAIN counts 1099 cycles with `dp_write`=0; returns to IDLE; `out_valid` never asserted.
- Early done:
  - Stimulus: force `dp_done` at progress=100.
  - Response: DONE with err=1; `out_valid` held until ack.
- Missing done:
  - Stimulus: tie `dp_done`=0.
  - Response: after 1600 EXEC cycles, 1600 DRAIN cycles, then DONE with err=1 via watchdog.
- Start/ack edge cases:
  - Stimulus: `start` pulsed during EXEC and DONE; `out_ack` asserted in IDLE.
  - Response: all ignored, no state change; `abort` at progress=1599 ignored, err=0.
- Async reset:
  - Stimulus: `rst` at progress=800.
  - Response: `ready`=1 and `busy`=`dp_count`=`dp_write`=0 within the same cycle; a following `start` completes in 1601 cycles.

Source files
------------

// File: rtl/revaluate_ctrl.sv
// rtl/revaluate_ctrl.sv - sequencing controller for the revaluate datapath
// Drives count/write one cell per clock, cross-checks datapath done, realigns counters after abort/error.
module revaluate_ctrl #(
  parameter int NUM_ITER = 1600,
  parameter int CNT_W    = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             dp_done,
  input  logic             out_ack,
  output logic             dp_count,
  output logic             dp_write,
  output logic             ready,
  output logic             busy,
  output logic             out_valid,
  output logic             err,
  output logic [CNT_W-1:0] progress
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DRAIN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CELL = CNT_W'(NUM_ITER - 1);
  localparam logic [CNT_W-1:0] SAT_CELL  = CNT_W'(NUM_ITER);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] progress_q, progress_nxt, progress_inc;
  logic             err_q, err_nxt;
  logic             aborted_q, aborted_nxt;
  logic             last_cell;

  assign last_cell    = (progress_q == LAST_CELL);
  assign progress_inc = (progress_q == SAT_CELL) ? progress_q : progress_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      progress_q <= '0;
      err_q      <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      progress_q <= progress_nxt;
      err_q      <= err_nxt;
      aborted_q  <= aborted_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    progress_nxt = progress_q;
    err_nxt      = err_q;
    aborted_nxt  = aborted_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt    = S_EXEC;
          progress_nxt = '0;
          err_nxt      = 1'b0;
          aborted_nxt  = 1'b0;
        end
      end
      S_EXEC: begin
        progress_nxt = progress_inc;
        // Abort on the last cell is dropped: the datapath is already at wrap.
        if (abort && !last_cell) begin
          state_nxt    = S_DRAIN;
          progress_nxt = '0;
          aborted_nxt  = 1'b1;
        end else if (last_cell) begin
          if (dp_done) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt    = S_DRAIN;
            progress_nxt = '0;
            err_nxt      = 1'b1;
          end
        end else if (dp_done) begin
          state_nxt = S_DONE;
          err_nxt   = 1'b1;
        end
      end
      S_DRAIN: begin
        // progress doubles as the drain watchdog here
        progress_nxt = progress_inc;
        if (dp_done) begin
          state_nxt = aborted_q ? S_IDLE : S_DONE;
        end else if (last_cell) begin
          state_nxt = S_DONE;
          err_nxt   = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ack) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign ready     = (state == S_IDLE);
  assign busy      = (state == S_EXEC) || (state == S_DRAIN);
  assign dp_write  = (state == S_EXEC);
  assign dp_count  = (state == S_EXEC) || (state == S_DRAIN);
  assign out_valid = (state == S_DONE);
  assign err       = (state == S_DONE) && err_q;
  assign progress  = progress_q;

endmodule

// File: tb/tb_revaluate_ctrl.sv
// tb/tb_revaluate_ctrl.sv - self-checking bench for revaluate_ctrl
// Timeline reference model plus a modulo-1600 datapath counter model.
module tb_revaluate_ctrl;

  localparam int N = 1600;
  localparam int M_NORMAL = 0, M_ABORT = 1, M_EARLY = 2, M_MISS = 3;
  localparam int P_IDLE = 0, P_ACT = 1, P_DONE = 2;

  logic clk = 1'b0;
  logic rst, start, out_ack, abort_noise, abort, dp_done;
  logic dp_count, dp_write, ready, busy, out_valid, err;
  logic [10:0] progress;

  int checks = 0, failures = 0, cyc = 0;
  int cfg_mode, cfg_arg;
  int dp_cnt;
  int n_wr = 0, n_drain = 0, n_valid = 0;

  int m_phase, m_t, m_w, m_d;
  logic m_end_done, m_err;
  logic [10:0] m_prog, m_pfin;
  int p_w, p_d;
  logic p_done, p_err;
  logic [10:0] p_fin;
  logic [16:0] exp_v;

  revaluate_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dp_done(dp_done),
    .out_ack(out_ack), .dp_count(dp_count), .dp_write(dp_write), .ready(ready),
    .busy(busy), .out_valid(out_valid), .err(err), .progress(progress)
  );

  always #5 clk = ~clk;

  task automatic finish_tb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      if (failures >= 200) finish_tb();
    end
  endtask

  // Datapath page counter: wraps every 1600 counts, done on the wrapping count.
  assign dp_done = dp_count && ((cfg_mode == M_EARLY) ? (m_phase == P_ACT && m_t == cfg_arg + 1) :
                                (cfg_mode == M_MISS)  ? 1'b0 : (dp_cnt == N - 1));
  assign abort = abort_noise || (cfg_mode == M_ABORT && m_phase == P_ACT && m_t == cfg_arg + 1);

  always @(posedge clk or posedge rst) begin
    if (rst) dp_cnt <= 0;
    else if (dp_count) dp_cnt <= (dp_done || dp_cnt == N - 1) ? 0 : dp_cnt + 1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dp_write) n_wr <= n_wr + 1;
    if (dp_count && !dp_write) n_drain <= n_drain + 1;
    if (out_valid) n_valid <= n_valid + 1;
  end

  // Pass plan: write cycles, drain cycles, how it ends, and final progress.
  always_comb begin
    p_w = N; p_d = 0; p_done = 1'b1; p_err = 1'b0; p_fin = 11'(N);
    case (cfg_mode)
      M_ABORT: if (cfg_arg < N - 1) begin
        p_w = cfg_arg + 1; p_d = N - 1 - cfg_arg; p_done = 1'b0; p_fin = 11'(N - 1 - cfg_arg);
      end
      M_EARLY: begin p_w = cfg_arg + 1; p_err = 1'b1; p_fin = 11'(cfg_arg + 1); end
      M_MISS:  begin p_d = N; p_err = 1'b1; end
      default: ;
    endcase
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= P_IDLE; m_t <= 0; m_prog <= '0; m_err <= 1'b0;
      m_w <= 0; m_d <= 0; m_end_done <= 1'b0; m_pfin <= '0;
    end else begin
      case (m_phase)
        P_IDLE: if (start) begin
          m_phase <= P_ACT; m_t <= 1;
          m_w <= p_w; m_d <= p_d; m_end_done <= p_done; m_err <= p_err; m_pfin <= p_fin;
        end
        P_ACT: if (m_t == m_w + m_d) begin
          m_phase <= m_end_done ? P_DONE : P_IDLE;
          m_prog  <= m_pfin;
        end else m_t <= m_t + 1;
        default: if (out_ack) m_phase <= P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_phase == P_IDLE)
      exp_v = {6'b100000, m_prog};
    else if (m_phase == P_ACT && m_t <= m_w)
      exp_v = {6'b011100, 11'(m_t - 1)};
    else if (m_phase == P_ACT)
      exp_v = {6'b011000, 11'(m_t - m_w - 1)};
    else
      exp_v = {5'b00001, m_err, m_prog};
    check("cycle_outputs", {15'd0, ready, busy, dp_count, dp_write, out_valid, err, progress}, {15'd0, exp_v});
  end

  task automatic run_pass(input int mode, input int arg, output int lat, output int wr,
                          output int dr, output int vc, output logic e);
    int s_cyc, w0, d0, v0, budget, dwait;
    bit seen;
    cfg_mode = mode; cfg_arg = arg;
    @(posedge clk); #1;
    out_ack = 1'b1;
    @(posedge clk); #1;
    out_ack = 1'b0; start = 1'b1; s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    w0 = n_wr; d0 = n_drain; v0 = n_valid;
    lat = -1; e = 1'b0; seen = 0; budget = 0; dwait = $urandom_range(0, 4);
    while (m_phase != P_IDLE && budget < 5000) begin
      if (out_valid && !seen) begin seen = 1; lat = cyc - s_cyc; e = err; end
      abort_noise = ((m_phase == P_DONE) || (m_phase == P_ACT && m_t > m_w)) && ($urandom_range(0, 15) == 0);
      start = (m_phase != P_IDLE) && ($urandom_range(0, 63) == 0);
      out_ack = 1'b0;
      if (m_phase == P_DONE) begin
        if (dwait == 0) begin out_ack = 1'b1; start = 1'($urandom_range(0, 1)); end
        else dwait--;
      end
      @(posedge clk); #1;
      budget++;
    end
    start = 1'b0; out_ack = 1'b0; abort_noise = 1'b0;
    check("pass_terminates", 32'(budget < 5000), 32'd1);
    @(negedge clk); #1;
    wr = n_wr - w0; dr = n_drain - d0; vc = n_valid - v0;
  endtask

  initial begin
    int lat, wr, dr, vc;
    logic e;
    rst = 1'b1; start = 1'b0; out_ack = 1'b0; abort_noise = 1'b0;
    cfg_mode = M_NORMAL; cfg_arg = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {15'd0, ready, busy, dp_count, dp_write, out_valid, err, progress}, 32'h10000);
    rst = 1'b0;

    run_pass(M_NORMAL, 0, lat, wr, dr, vc, e);
    check("normal_latency", lat, 1601);
    check("normal_writes", wr, 1600);
    check("normal_drain", dr, 0);
    check("normal_err", 32'(e), 0);

    run_pass(M_ABORT, 500, lat, wr, dr, vc, e);
    check("abort_writes", wr, 501);
    check("abort_drain", dr, 1099);
    check("abort_no_valid", vc, 0);

    run_pass(M_EARLY, 100, lat, wr, dr, vc, e);
    check("early_err", 32'(e), 1);
    check("early_writes", wr, 101);
    check("early_latency", lat, 102);

    run_pass(M_MISS, 0, lat, wr, dr, vc, e);
    check("miss_writes", wr, 1600);
    check("miss_drain", dr, 1600);
    check("miss_err", 32'(e), 1);
    check("miss_latency", lat, 3201);

    run_pass(M_ABORT, 1599, lat, wr, dr, vc, e);
    check("late_abort_err", 32'(e), 0);
    check("late_abort_writes", wr, 1600);
    check("late_abort_latency", lat, 1601);

    cfg_mode = M_NORMAL; cfg_arg = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (800) @(posedge clk);
    #1;
    check("progress_before_rst", 32'(progress), 800);
    #1 rst = 1'b1;
    #1;
    check("async_rst_outputs", {15'd0, ready, busy, dp_count, dp_write, out_valid, err, progress}, 32'h10000);
    @(posedge clk); #1 rst = 1'b0;

    run_pass(M_NORMAL, 0, lat, wr, dr, vc, e);
    check("post_rst_latency", lat, 1601);

    for (int i = 0; i < 6; i++) begin
      int md, ag;
      md = $urandom_range(0, 3);
      ag = (md == M_ABORT) ? $urandom_range(0, 1599) : $urandom_range(0, 1598);
      run_pass(md, ag, lat, wr, dr, vc, e);
    end

    finish_tb();
  end

endmodule
